// File: rtl/instruction_queue_pkg.sv
// Shared CPU decode types and the instruction queue's default sizing.
package instruction_queue_pkg;

    typedef struct packed {
        logic       invalid;
        logic       has_modrm;
        logic [3:0] length;
        logic [7:0] modrm;
        logic [7:0] opcode;
    } Instruction;

    localparam int INSN_QUEUE_DEPTH        = 4;
    localparam int INSN_QUEUE_FLUSH_CYCLES = 2;

    typedef enum logic {
        IQ_IDLE     = 1'b0,
        IQ_FLUSHING = 1'b1
    } iq_state_e;

endpackage

// File: rtl/instruction_queue.sv
// Show-ahead buffer of decoded instructions between decoder and sequencer,
// with a timed flush window while the decoder drains stale bytes.
//   state       | meaning
//   IQ_IDLE     | normal push/pop traffic
//   IQ_FLUSHING | contents discarded, writes blocked until the timer expires
module instruction_queue
    import instruction_queue_pkg::*;
#(
    parameter int DEPTH        = INSN_QUEUE_DEPTH,
    parameter int FLUSH_CYCLES = INSN_QUEUE_FLUSH_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  Instruction             wr_data,
    output logic                   full,
    input  logic                   rd_en,
    output Instruction             rd_data,
    output logic                   empty,
    input  logic                   flush,
    output logic                   resetting,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(FLUSH_CYCLES + 1);

    Instruction    mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_ok, rd_ok;

    iq_state_e     state_q;
    logic [TW-1:0] timer_q;
    logic          resetting_q;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign resetting = resetting_q;
    assign rd_data   = empty ? Instruction'('0) : mem_q[rd_ptr_q];

    assign wr_ok = wr_en && !full && !resetting_q && !flush;
    assign rd_ok = rd_en && !empty && !flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_ok) rd_ptr_d = rd_ptr_q + PW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entries need no reset: the empty gating hides stale contents.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IQ_IDLE;
            timer_q     <= '0;
            resetting_q <= 1'b0;
        end else begin
            case (state_q)
                IQ_IDLE: begin
                    if (flush) begin
                        state_q     <= IQ_FLUSHING;
                        timer_q     <= TW'(FLUSH_CYCLES - 1);
                        resetting_q <= 1'b1;
                    end
                end
                IQ_FLUSHING: begin
                    if (flush) begin
                        timer_q     <= TW'(FLUSH_CYCLES - 1);
                        resetting_q <= 1'b1;
                    end else if (timer_q == '0) begin
                        state_q     <= IQ_IDLE;
                        resetting_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: begin
                    state_q     <= IQ_IDLE;
                    resetting_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue (DEPTH=4, FLUSH_CYCLES=2).
module tb_instruction_queue;
    import instruction_queue_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en, rd_en, flush;
    Instruction wr_data;
    Instruction rd_data;
    logic       full, empty, resetting;
    logic [2:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_queue #(.DEPTH(4), .FLUSH_CYCLES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .flush     (flush),
        .resetting (resetting),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic Instruction mk(input logic [7:0] op);
        Instruction d;
        d        = '0;
        d.opcode = op;
        d.length = 4'd1;
        return d;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_empty"},     32'(empty),     32'd1);
        check({tag, "_full"},      32'(full),      32'd0);
        check({tag, "_count"},     32'(count),     32'd0);
        check({tag, "_resetting"}, 32'(resetting), 32'd0);
        check({tag, "_rd_data"},   32'(rd_data),   32'd0);
    endtask

    logic [7:0] ops [4];
    Instruction d55;

    initial begin
        ops[0] = 8'h90; ops[1] = 8'h01; ops[2] = 8'hF4; ops[3] = 8'hCD;
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; wr_data = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check_idle_outputs("reset");

        // pop while empty
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("pop_empty_count", 32'(count), 32'd0);
        check("pop_empty_empty", 32'(empty), 32'd1);

        // fill to full
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = mk(ops[i]);
            tick();
            check("fill_count", 32'(count), 32'(i + 1));
        end
        check("fill_full", 32'(full), 32'd1);
        wr_data = mk(8'hEB);
        tick();
        wr_en = 1'b0;
        check("drop5_count", 32'(count), 32'd4);
        check("drop5_head",  32'(rd_data.opcode), 32'h90);

        for (int i = 0; i < 4; i++) begin
            check("drain_order", 32'(rd_data.opcode), 32'(ops[i]));
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_data",  32'(rd_data), 32'd0);

        // steady push+pop at count 2 across pointer wrap
        for (int i = 0; i < 2; i++) begin
            wr_en = 1'b1; wr_data = mk(8'(8'h10 + i));
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; wr_data = mk(8'(8'h12 + i));
            check("stream_head", 32'(rd_data.opcode), 32'(8'h10 + i));
            tick();
            check("stream_count", 32'(count), 32'd2);
        end
        wr_en = 1'b0;
        check("stream_tail0", 32'(rd_data.opcode), 32'h1A);
        tick();
        check("stream_tail1", 32'(rd_data.opcode), 32'h1B);
        tick();
        rd_en = 1'b0;
        check("stream_empty", 32'(empty), 32'd1);

        // push into empty with concurrent pop
        d55 = mk(8'h55); d55.has_modrm = 1'b1; d55.modrm = 8'hC3;
        wr_en = 1'b1; rd_en = 1'b1; wr_data = d55;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("wr_at_empty_count", 32'(count), 32'd1);
        check("wr_at_empty_data",  32'(rd_data), 32'(d55));

        // flush at count 3 with concurrent traffic
        wr_en = 1'b1; wr_data = mk(8'h60); tick();
        wr_data = mk(8'h61); tick();
        check("preflush_count", 32'(count), 32'd3);
        rd_en = 1'b1; flush = 1'b1; wr_data = mk(8'h62);
        tick();
        rd_en = 1'b0; flush = 1'b0;
        check("flush_empty",     32'(empty),     32'd1);
        check("flush_count",     32'(count),     32'd0);
        check("flush_resetting", 32'(resetting), 32'd1);
        wr_data = mk(8'h70);
        tick();
        check("win1_resetting", 32'(resetting), 32'd1);
        check("win1_count",     32'(count),     32'd0);
        wr_data = mk(8'h71);
        tick();
        check("win2_resetting", 32'(resetting), 32'd0);
        check("win2_count",     32'(count),     32'd0);
        wr_data = mk(8'h72);
        tick();
        wr_en = 1'b0;
        check("post_flush_count", 32'(count), 32'd1);
        check("post_flush_data",  32'(rd_data.opcode), 32'h72);

        // re-flush one cycle into the window
        flush = 1'b1;
        tick();
        check("ref_a_resetting", 32'(resetting), 32'd1);
        tick();
        flush = 1'b0;
        check("ref_b_resetting", 32'(resetting), 32'd1);
        tick();
        check("ref_c_resetting", 32'(resetting), 32'd1);
        tick();
        check("ref_d_resetting", 32'(resetting), 32'd0);

        // async reset mid-transfer
        wr_en = 1'b1; wr_data = mk(8'h80); tick();
        wr_data = mk(8'h81); tick();
        wr_en = 1'b0;
        check("pre_rst_count", 32'(count), 32'd2);
        #2 reset = 1'b1;
        #1;
        check_idle_outputs("async_rst_xfer");
        #2 reset = 1'b0;

        // async reset mid-flush window
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("pre_rst_resetting", 32'(resetting), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_idle_outputs("async_rst_flush");
        #2 reset = 1'b0;
        tick();
        check("after_rst_resetting", 32'(resetting), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
